// File: rtl/uart16550_pkg.sv
// Shared UART 16550 types: line control, received character, receiver FSM states.
package uart16550_pkg;

  typedef enum logic [1:0] {WLS_5 = 2'b00, WLS_6 = 2'b01, WLS_7 = 2'b10, WLS_8 = 2'b11} wls_t;
  typedef enum logic {EPS_ODD = 1'b0, EPS_EVEN = 1'b1} eps_t;

  typedef struct packed {
    wls_t wls;
    logic stb;
    logic pen;
    eps_t eps;
    logic stick_parity;
  } lcr_t;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } rx_d_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  localparam logic [3:0] RX_SAMPLE_TICK = 4'd7;

  // Four character times in 16x ticks: 64 * (start + data + parity + stop bits).
  function automatic logic [9:0] rx_timeout_limit(input lcr_t l);
    logic [3:0] n;
    n = 4'd7 + {2'd0, l.wls} + {3'd0, l.pen} + {3'd0, l.stb};
    return {n, 6'd0};
  endfunction

endpackage

// File: rtl/uart16550_sync.sv
// Multi-stage synchronizer for the asynchronous serial input; stages reset to idle-high.
// Latency STAGES cycles, no backpressure.
module uart16550_sync #(
  parameter int STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_q <= '1;
    else          r_q <= {r_q[STAGES-2:0], i_d};
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/uart16550_rx.sv
// UART 16550 receiver: 16x oversampled, push strobe one cycle after the stop-bit sample, no backpressure.
// Optional character timeout under UART16550_RX_TIMEOUT_EN.
module uart16550_rx
  import uart16550_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic  PCLK,
  input  logic  PRESETn,
  input  logic  rx_tick,
  input  logic  sin,
  input  lcr_t  lcr,
  input  logic  rx_fifo_empty,
  input  logic  rx_pop,
  output logic  rx_push,
  output rx_d_t rx_d,
  output logic  rx_busy,
  output logic  rx_timeout
);

  logic      w_rxs;
  rx_state_t r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_data;
  logic [1:0] r_wls;
  logic      r_pen, r_eps, r_stick;
  logic      r_pe, r_all_zero;
  logic      r_push, r_busy;
  rx_d_t     r_d;
  logic      w_sample, w_last_bit, w_exp_par;

  uart16550_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .i_d     (sin),
    .o_q     (w_rxs)
  );

  // The tick counter free-runs mod 16 after the start edge, so every bit is sampled at count 7.
  assign w_sample   = rx_tick && (r_tick_cnt == RX_SAMPLE_TICK);
  assign w_last_bit = (r_bit_cnt == ({1'b0, r_wls} + 3'd4));

  always_comb begin
    w_exp_par = 1'b0;
    if (r_stick)    w_exp_par = ~r_eps;
    else if (r_eps) w_exp_par = ^r_data;
    else            w_exp_par = ~^r_data;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_wls      <= '0;
      r_pen      <= 1'b0;
      r_eps      <= 1'b0;
      r_stick    <= 1'b0;
      r_pe       <= 1'b0;
      r_all_zero <= 1'b0;
      r_push     <= 1'b0;
      r_busy     <= 1'b0;
      r_d        <= '0;
    end else begin
      r_push <= 1'b0;
      if (rx_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
      case (r_state)
        IDLE: begin
          r_tick_cnt <= '0;
          if (!w_rxs) r_state <= START;
        end
        START: if (w_sample) begin
          if (w_rxs) begin
            r_state <= IDLE;
          end else begin
            r_wls      <= lcr.wls;
            r_pen      <= lcr.pen;
            r_eps      <= lcr.eps;
            r_stick    <= lcr.stick_parity;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_pe       <= 1'b0;
            r_all_zero <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= DATA;
          end
        end
        DATA: if (w_sample) begin
          r_data[r_bit_cnt] <= w_rxs;
          r_all_zero        <= r_all_zero & ~w_rxs;
          r_bit_cnt         <= r_bit_cnt + 3'd1;
          if (w_last_bit) r_state <= r_pen ? PARITY : STOP;
        end
        PARITY: if (w_sample) begin
          r_pe       <= w_rxs ^ w_exp_par;
          r_all_zero <= r_all_zero & ~w_rxs;
          r_state    <= STOP;
        end
        STOP: if (w_sample) begin
          r_push <= 1'b1;
          if (r_all_zero && !w_rxs) begin
            r_d     <= '{bi: 1'b1, fe: 1'b1, pe: 1'b0, d: 8'h00};
            r_state <= BREAK;
          end else begin
            r_d     <= '{bi: 1'b0, fe: ~w_rxs, pe: r_pe, d: r_data};
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        BREAK: if (w_rxs) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_push = r_push;
  assign rx_d    = r_d;
  assign rx_busy = r_busy;

`ifdef UART16550_RX_TIMEOUT_EN
  logic [9:0] r_to_cnt;
  logic       r_timeout;
  logic [9:0] w_to_limit;

  assign w_to_limit = rx_timeout_limit(lcr);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_push || rx_pop || rx_fifo_empty) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (rx_tick && (r_to_cnt < w_to_limit)) begin
      r_to_cnt <= r_to_cnt + 10'd1;
      if ((r_to_cnt + 10'd1) >= w_to_limit) r_timeout <= 1'b1;
    end
  end

  assign rx_timeout = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = &{rx_fifo_empty, rx_pop, lcr.stb};
  assign rx_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart16550_rx.sv
// Directed bench for uart16550_rx; the timeout vector depends on UART16550_RX_TIMEOUT_EN.
module tb_uart16550_rx;
  import uart16550_pkg::*;

  logic  PCLK, PRESETn, rx_tick, sin, rx_fifo_empty, rx_pop;
  lcr_t  lcr;
  logic  rx_push, rx_busy, rx_timeout;
  rx_d_t rx_d;

  int n_vec = 0, n_miss = 0;
  int cyc = 0, tick_div = 1, tdiv_cnt = 0;
  int push_cnt = 0, last_cyc = 0, t_start = 0, base = 0;
  logic [10:0] last_d = '0;

  uart16550_rx #(.SYNC_STAGES(2)) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .rx_tick       (rx_tick),
    .sin           (sin),
    .lcr           (lcr),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_pop        (rx_pop),
    .rx_push       (rx_push),
    .rx_d          (rx_d),
    .rx_busy       (rx_busy),
    .rx_timeout    (rx_timeout)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (tick_div <= 1) begin
      rx_tick = 1'b1;
    end else begin
      rx_tick  = (tdiv_cnt == 0);
      tdiv_cnt = (tdiv_cnt + 1) % tick_div;
    end
  end

  always @(negedge PCLK) begin
    if (rx_push) begin
      push_cnt = push_cnt + 1;
      last_d   = rx_d;
      last_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic lcr_t mk_lcr(input logic [1:0] w, input logic stb, input logic pen,
                                  input logic eps, input logic stk);
    lcr_t l;
    l.wls          = wls_t'(w);
    l.stb          = stb;
    l.pen          = pen;
    l.eps          = eps_t'(eps);
    l.stick_parity = stk;
    return l;
  endfunction

  // One frame; mid_lcr is applied right after the start bit.
  task automatic send_char(input logic [7:0] d, input int nbits, input logic has_par,
                           input logic par, input logic stop, input int stop_ticks,
                           input lcr_t mid_lcr);
    int bc;
    bc = 16 * tick_div;
    @(negedge PCLK);
    sin = 1'b0;
    t_start = cyc;
    repeat (bc) @(negedge PCLK);
    lcr = mid_lcr;
    for (int i = 0; i < nbits; i++) begin
      sin = d[i];
      repeat (bc) @(negedge PCLK);
    end
    if (has_par) begin
      sin = par;
      repeat (bc) @(negedge PCLK);
    end
    sin = stop;
    repeat (stop_ticks * tick_div) @(negedge PCLK);
    sin = 1'b1;
    repeat (2 * bc) @(negedge PCLK);
    #1;
  endtask

  lcr_t l8n1, l5n1, l7e1, l8s1;

  initial begin
    l8n1 = mk_lcr(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    l5n1 = mk_lcr(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    l7e1 = mk_lcr(2'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    l8s1 = mk_lcr(2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    PRESETn = 1'b0; sin = 1'b1; rx_fifo_empty = 1'b1; rx_pop = 1'b0; lcr = l8n1;
    tick_div = 1;
    repeat (3) @(negedge PCLK);
    #1;
    chk("rst_push", rx_push, 1'b0);
    chk("rst_d", rx_d, 11'h000);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_timeout", rx_timeout, 1'b0);
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);

    // 8N1 0xA5, one tick per cycle; lcr switched to 5N1 mid-character must be ignored.
    base = push_cnt;
    send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16, l5n1);
    chk("a5_pushes", push_cnt - base, 1);
    chk("a5_d", last_d, 11'h0A5);
    chk("a5_latency", last_cyc - t_start, 155);

    tick_div = 4;
    lcr = l7e1;
    repeat (8) @(negedge PCLK);
    base = push_cnt;
    send_char(8'h35, 7, 1'b1, 1'b1, 1'b1, 16, l7e1);
    chk("7e1_bad_pushes", push_cnt - base, 1);
    chk("7e1_bad_d", last_d, 11'h135);
    send_char(8'h35, 7, 1'b1, 1'b0, 1'b1, 16, l7e1);
    chk("7e1_good_d", last_d, 11'h035);

    lcr = l8s1;
    send_char(8'h00, 8, 1'b1, 1'b1, 1'b1, 16, l8s1);
    chk("stick_d", last_d, 11'h000);

    lcr = l5n1;
    base = push_cnt;
    send_char(8'h1F, 5, 1'b0, 1'b0, 1'b0, 12, l5n1);
    chk("5n1_fe_pushes", push_cnt - base, 1);
    chk("5n1_fe_d", last_d, 11'h21F);

    // Break: two character times low.
    lcr = l8n1;
    base = push_cnt;
    @(negedge PCLK);
    sin = 1'b0;
    repeat (2 * 10 * 16 * tick_div) @(negedge PCLK);
    #1;
    chk("brk_pushes", push_cnt - base, 1);
    chk("brk_d", last_d, 11'h600);
    chk("brk_busy_low", rx_busy, 1'b1);
    @(negedge PCLK);
    sin = 1'b1;
    repeat (32 * tick_div) @(negedge PCLK);
    #1;
    chk("brk_busy_high", rx_busy, 1'b0);
    chk("brk_no_extra", push_cnt - base, 1);
    send_char(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16, l8n1);
    chk("post_brk_pushes", push_cnt - base, 2);
    chk("post_brk_d", last_d, 11'h05A);

    // False start: 4-tick low pulse.
    base = push_cnt;
    @(negedge PCLK);
    sin = 1'b0;
    repeat (4 * tick_div) @(negedge PCLK);
    sin = 1'b1;
    repeat (32 * tick_div) @(negedge PCLK);
    #1;
    chk("glitch_pushes", push_cnt - base, 0);
    chk("glitch_busy", rx_busy, 1'b0);

    // Reset in the middle of the data bits.
    base = push_cnt;
    @(negedge PCLK);
    sin = 1'b0;
    repeat (16 * tick_div + 3 * 16 * tick_div) @(negedge PCLK);
    #1;
    chk("mid_busy", rx_busy, 1'b1);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("mid_rst_push", rx_push, 1'b0);
    chk("mid_rst_d", rx_d, 11'h000);
    chk("mid_rst_busy", rx_busy, 1'b0);
    chk("mid_rst_timeout", rx_timeout, 1'b0);
    sin = 1'b1;
    repeat (4) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (2 * 10 * 16 * tick_div) @(negedge PCLK);
    #1;
    chk("post_rst_pushes", push_cnt - base, 0);

    // Character timeout, 8N1, FIFO non-empty, one tick per cycle.
    tick_div = 1;
    lcr = l8n1;
    repeat (4) @(negedge PCLK);
    rx_fifo_empty = 1'b0;
    repeat (639) @(negedge PCLK);
    #1;
    chk("to_639", rx_timeout, 1'b0);
    @(negedge PCLK);
    #1;
`ifdef UART16550_RX_TIMEOUT_EN
    chk("to_640", rx_timeout, 1'b1);
`else
    chk("to_640_off", rx_timeout, 1'b0);
`endif
    @(negedge PCLK);
    rx_pop = 1'b1;
    @(negedge PCLK);
    rx_pop = 1'b0;
    #1;
    chk("to_pop_clear", rx_timeout, 1'b0);
    rx_fifo_empty = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
